// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// The multiply path is shift-add and the divide path is a restoring divider.
// Both work on operand magnitudes, and the sign is fixed up when the result
// is written. Divide-by-zero and signed overflow skip the iteration phase.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// leaves CALC as soon as the remaining multiplier is zero.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wa,
    output logic            we
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          wa_q, wa_d;
    logic [XLEN-1:0]     result_q, result_d;
    // acc: 64-bit product for a multiply; {remainder, dividend/quotient} for a divide
    logic [2*XLEN-1:0]   acc_q, acc_d;
    // opnd: multiplicand shifted left for a multiply; divisor in the low half for a divide
    logic [2*XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic                neg_q, neg_d;

    // Issue-time decode and magnitude preparation
    logic            a_sgn_op, b_sgn_op, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    // Per-iteration datapath temporaries
    logic [XLEN:0]     shifted_rem;
    logic [XLEN-1:0]   diff_rem;
    logic              rem_ge;
    logic              last_iter;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_part;

    // Next-state, datapath iteration and result formation
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        wa_d        = wa_q;
        result_d    = result_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;

        a_sgn_op    = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                      (funct3 == F_DIV) || (funct3 == F_REM);
        b_sgn_op    = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                      (funct3 == F_DIV) || (funct3 == F_REM);
        a_neg       = a_sgn_op && op_a[XLEN-1];
        b_neg       = b_sgn_op && op_b[XLEN-1];
        mag_a       = a_neg ? (~op_a + 1'b1) : op_a;
        mag_b       = b_neg ? (~op_b + 1'b1) : op_b;

        shifted_rem = acc_q[2*XLEN-1:XLEN-1];
        rem_ge      = shifted_rem >= {1'b0, opnd_q[XLEN-1:0]};
        diff_rem    = shifted_rem[XLEN-1:0] - opnd_q[XLEN-1:0];
        last_iter   = 1'b0;
        prod_signed = '0;
        div_part    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d  = funct3;
                    wa_d  = rd_in;
                    cnt_d = '0;
                    if (funct3[2] && (op_b == '0)) begin
                        // Divide by zero: quotient is all ones, remainder is the dividend
                        result_d = funct3[1] ? op_a : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (funct3[2] && !funct3[0] &&
                                 (op_a == INT_MIN) && (op_b == ALL_ONES)) begin
                        // Signed overflow: quotient is INT_MIN, remainder is zero
                        result_d = funct3[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else if (funct3[2]) begin
                        acc_d    = {{XLEN{1'b0}}, mag_a};
                        opnd_d   = {{XLEN{1'b0}}, mag_b};
                        mplier_d = '0;
                        neg_d    = funct3[1] ? a_neg : (a_neg ^ b_neg);
                        state_d  = S_CALC;
                    end else begin
                        acc_d    = '0;
                        opnd_d   = {{XLEN{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        neg_d    = a_neg ^ b_neg;
                        state_d  = S_CALC;
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (f3_q[2]) begin
                    // One restoring-divide step: shift the next dividend bit in and try to subtract
                    acc_d = rem_ge ? {diff_rem, acc_q[XLEN-2:0], 1'b1}
                                   : {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    // One shift-add step, driven by the multiplier LSB
                    if (mplier_q[0]) begin
                        acc_d = acc_q + opnd_q;
                    end
                    opnd_d   = opnd_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                last_iter = (cnt_q == LAST_CNT);
`ifdef MULDIV_EARLY_OUT_EN
                if (!f3_q[2] && (mplier_d == '0)) begin
                    last_iter = 1'b1;
                end
`endif
                if (last_iter) begin
                    prod_signed = neg_q ? (~acc_d + 1'b1) : acc_d;
                    div_part    = f3_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
                    if (f3_q[2]) begin
                        result_d = neg_q ? (~div_part + 1'b1) : div_part;
                    end else if (f3_q == F_MUL) begin
                        result_d = prod_signed[XLEN-1:0];
                    end else begin
                        result_d = prod_signed[2*XLEN-1:XLEN];
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulators are cleared as well, so an op abandoned by reset leaves no residue in them.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            wa_q     <= '0;
            result_q <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates, so every register samples the values from before this edge.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            wa_q     <= wa_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign we     = done;
    assign result = result_q;
    assign wa     = wa_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default build: fixed 33-cycle latency).
module tb_muldiv_unit;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
    localparam int MAX_WAIT = 100;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a   = '0;
    logic [31:0] op_b   = '0;
    logic [4:0]  rd_in  = '0;
    logic        busy, done, we;
    logic [31:0] result;
    logic [4:0]  wa;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa     (wa),
        .we     (we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one start request; returns just after the sampling edge (cycle 1), with inputs scrambled.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    // Step until done is seen or the cycle budget runs out; cyc is the cycle index of done.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        issue(f, a, b, rd);
        wait_done(1, cyc);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] || exp_lat == 1) check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
`else
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
`endif
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " wa"}, 64'(wa), 64'(rd));
        check({tag, " we/busy at done"}, {62'd0, we, busy}, 64'd3);
        @(posedge clk);
        #1;
        check({tag, " idle after done"}, {61'd0, done, we, busy}, 64'd0);
        check({tag, " result held"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int cyc;
        logic seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, we, wa, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply
        run_op("MUL 7*6",          MUL,    32'd7,        32'd6,        5'd5,  32'd42,       33);
        run_op("MULH -1*2",        MULH,   32'hFFFFFFFF, 32'd2,        5'd1,  32'hFFFFFFFF, 33);
        run_op("MULHU ffff*2",     MULHU,  32'hFFFFFFFF, 32'd2,        5'd2,  32'h00000001, 33);
        run_op("MULHSU -1*ffff",   MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);
        run_op("MULHU ffff*ffff",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
        run_op("MUL -3*5",         MUL,    32'hFFFFFFFD, 32'd5,        5'd31, 32'hFFFFFFF1, 33);
        run_op("MUL rd0",          MUL,    32'd9,        32'd9,        5'd0,  32'd81,       33);

        // Divide
        run_op("DIV -7/2",         DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 33);
        run_op("REM -7%2",         REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 33);
        run_op("DIV 7/-2",         DIV,    32'd7,        32'hFFFFFFFE, 5'd8,  32'hFFFFFFFD, 33);
        run_op("REM 7%-2",         REM,    32'd7,        32'hFFFFFFFE, 5'd9,  32'd1,        33);
        run_op("DIVU 100/7",       DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       33);
        run_op("REMU 100%7",       REMU,   32'd100,      32'd7,        5'd11, 32'd2,        33);
        run_op("DIVU 8000/ffff",   DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        33);
        run_op("REMU 8000%ffff",   REMU,   32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 33);

        // Fast paths
        run_op("DIV 5/0",          DIV,    32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        run_op("REMU 5%0",         REMU,   32'd5,        32'd0,        5'd15, 32'd5,        1);
        run_op("DIV ovf",          DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        run_op("REM ovf",          REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);

        // A start while busy is ignored
        issue(DIVU, 32'd100, 32'd7, 5'd12);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start  = 1'b1;
        funct3 = MUL;
        op_a   = 32'd3;
        op_b   = 32'd5;
        rd_in  = 5'd20;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        wait_done(cyc, cyc);
        check("busy start latency", 64'(cyc), 64'd33);
        check("busy start result", 64'(result), 64'd14);
        check("busy start wa", 64'(wa), 64'd12);
        @(posedge clk);
        #1;
        check("busy start idle", {61'd0, done, we, busy}, 64'd0);

        // Back-to-back: new start in the idle cycle right after done
        run_op("b2b MUL 3*3",      MUL,    32'd3,        32'd3,        5'd3,  32'd9,        33);

        // Reset in the middle of a multiply
        issue(MUL, 32'h00010000, 32'h00010000, 5'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-op reset outputs", {busy, done, we, wa, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || we !== 1'b0) seen = 1'b1;
        end
        check("no done after reset", 64'(seen), 64'd0);
        run_op("post-reset MULHU", MULHU,  32'h00010000, 32'h00010000, 5'd7,  32'd1,        33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
